uart_tx: RTL
============

Name: uart_tx

Overview:
- Serial UART transmitter for the 64-bit packet link; the transmit end of the receiver in the same codebase.
- Accepts a 63-bit packet word (bits 62:0) and appends the odd-parity bit as bit 63.
- Serialises each frame LSB-first: one start bit (0), 64 data bits, STOP_BITS stop bits (1). One bit per clk.
- A one-entry holding register lets the next packet load while the current one shifts, so frames go back-to-back with no idle gap.

Parameters:
- WIDTH, 64: frame payload bits including parity. Parity sits at bit WIDTH-1; user data is WIDTH-1 bits.
- STOP_BITS, 1: stop-bit cycles per frame. Legal range 1..4.

Ports:
- clk, input, 1: transmit clock, one serial bit per cycle.
- reset_n, input, 1: asynchronous, active-low reset.
- tx_data, input, WIDTH-1: packet word to send (bits 62:0 of the packet).
- ld_tx_data, input, 1: load strobe, sampled on posedge clk.
- inj_parity_err, input, 1: sampled together with ld_tx_data. When 1, the parity bit of that frame is inverted (test use).
- tx_out, output, 1: serial line, registered, idles high.
- tx_empty, output, 1: holding register empty; a load will be accepted.
- tx_busy, output, 1: a frame is on the line (START through the last STOP cycle).
- ld_dropped, output, 1: one-cycle pulse when ld_tx_data arrives while tx_empty=0.

Behaviour:
- Reset values (asynchronous):
  - tx_out=1, tx_empty=1, tx_busy=0, ld_dropped=0.
  - state=IDLE; hold and shift registers = 0; bit counter = 0.
- Load:
  - Edge with ld_tx_data=1 and tx_empty=1: hold <= {parity, tx_data}, and tx_empty goes 0.
  - parity = ~^tx_data[WIDTH-2:0], XORed with inj_parity_err. The total count of 1s across all 64 bits is odd unless an error is injected.
  - Edge with ld_tx_data=1 and tx_empty=0: hold is unchanged and ld_dropped=1 for one cycle.
  - Acceptance uses the registered tx_empty value only. A load in the same cycle that hold drains is dropped.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_out=1, tx_busy=0.
    - If hold is full: shift <= hold, tx_empty<=1, state<=START.
    - First start bit appears on tx_out one cycle after tx_empty is seen low. Latency is 2 clk from the ld edge to tx_out=0.
  - START: tx_out=0 for exactly 1 cycle, then state<=DATA with bit_cnt=0.
  - DATA: tx_out=shift[0] and the shift register moves right, for exactly WIDTH cycles (bit_cnt 0..WIDTH-1). Then state<=STOP.
  - STOP: tx_out=1 for STOP_BITS cycles.
    - On the last cycle, if hold is full: shift<=hold, tx_empty<=1, state<=START. No idle cycle between frames.
    - Otherwise state<=IDLE.
- tx_busy is 1 in START, DATA and STOP. It is registered and aligned with tx_out.
- Frame length is 1+WIDTH+STOP_BITS cycles: 66 at defaults.
- tx_out comes straight from a flop, so it is glitch-free.
- Counter widths:
  - bit_cnt is $clog2(WIDTH)+1 bits and never wraps within a frame.
  - The stop counter is 2 bits.
- tx_data changes after an accepted load have no effect on that frame.
- reset_n asserted mid-frame: tx_out goes to 1 immediately, and any pending hold is discarded. The partial frame is truncated, and the receiver sees a stop-less frame.

Decomposition:
- uart_pkg holds:
  - localparam UART_WIDTH=64
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t
  - function odd_parity(input logic [62:0] d) returning ~^d, shared with the receiver's check
- Single module, no sub-module.
- A loopback wrapper uart_loopback (uart_tx driving the receiver) belongs in the testbench, not in RTL.

Test Plan:
- Reset, then load tx_data=63'h0 -> tx_out stays 1 until the start bit. Line then reads start 0, 63 zeros, bit63=1, stop 1; tx_busy is high for 66 cycles.
- Load tx_data=63'h1 -> serial bit0=1, bits1..62=0, parity bit=0. The receiver in loopback yields rx_data=63'h1 with parity_error=0.
- Load 63'h5A5A_5A5A_1234_5678 and, once tx_empty returns 1, immediately load 63'h7FFF_FFFF_FFFF_FFFF -> second start bit follows the first frame's stop bit with zero idle cycles. The receiver captures both words in order.
- Load while tx_empty=0 -> ld_dropped pulses once, and the frame in hold is unchanged on the line.
- inj_parity_err=1 with tx_data=63'h3 -> bit63=0 instead of 1, and the receiver flags parity_error=1.
- Assert reset_n low at data bit 30 -> tx_out=1, tx_busy=0, tx_empty=1 asynchronously. No frame is sent after release until a new load.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the 64-bit packet-link UART (transmitter and receiver).
package uart_pkg;

  localparam int unsigned UART_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // Odd parity over the 63 user bits; the receiver uses the same function for its check.
  function automatic logic odd_parity(input logic [62:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WIDTH data bits LSB-first (odd parity at the MSB), STOP_BITS stop bits.
// A one-entry holding register lets frames go out back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH     = UART_WIDTH,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-2:0] tx_data,
  input  logic             ld_tx_data,
  input  logic             inj_parity_err,
  output logic             tx_out,
  output logic             tx_empty,
  output logic             tx_busy,
  output logic             ld_dropped
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);

  uart_tx_state_t   state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [WIDTH-1:0] shift, shift_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [1:0]       stop_cnt, stop_cnt_nxt;
  logic             tx_out_nxt, tx_empty_nxt, tx_busy_nxt, ld_dropped_nxt;
  logic             parity_c;

  assign parity_c = odd_parity(63'(tx_data)) ^ inj_parity_err;

  // State and datapath registers; line output is a flop so it never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= '0;
      tx_out     <= 1'b1;
      tx_empty   <= 1'b1;
      tx_busy    <= 1'b0;
      ld_dropped <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      shift      <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      stop_cnt   <= stop_cnt_nxt;
      tx_out     <= tx_out_nxt;
      tx_empty   <= tx_empty_nxt;
      tx_busy    <= tx_busy_nxt;
      ld_dropped <= ld_dropped_nxt;
    end
  end

  // Next-state and output logic. Load acceptance (tx_empty=1) and hold drain
  // (tx_empty=0) are mutually exclusive, so they never fight over hold/tx_empty.
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold;
    shift_nxt      = shift;
    bit_cnt_nxt    = bit_cnt;
    stop_cnt_nxt   = stop_cnt;
    tx_empty_nxt   = tx_empty;
    ld_dropped_nxt = 1'b0;
    tx_out_nxt     = 1'b1;
    tx_busy_nxt    = 1'b0;

    if (ld_tx_data) begin
      if (tx_empty) begin
        hold_nxt     = {parity_c, tx_data};
        tx_empty_nxt = 1'b0;
      end else begin
        ld_dropped_nxt = 1'b1;
      end
    end

    unique case (state)
      IDLE: begin
        if (!tx_empty) begin
          shift_nxt    = hold;
          tx_empty_nxt = 1'b1;
          state_nxt    = START;
        end
      end
      START: begin
        tx_out_nxt  = 1'b0;
        tx_busy_nxt = 1'b1;
        bit_cnt_nxt = '0;
        state_nxt   = DATA;
      end
      DATA: begin
        tx_out_nxt  = shift[0];
        tx_busy_nxt = 1'b1;
        shift_nxt   = shift >> 1;
        if (bit_cnt == LAST_BIT) begin
          stop_cnt_nxt = '0;
          state_nxt    = STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_busy_nxt = 1'b1;
        if (stop_cnt == LAST_STOP) begin
          if (!tx_empty) begin
            shift_nxt    = hold;
            tx_empty_nxt = 1'b1;
            state_nxt    = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          stop_cnt_nxt = stop_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
